// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking loop-detector front end.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GATE,
    SERVED,
    FAULT
  } lane_state_t;

  localparam int STUCK_W             = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_STUCK_CYCLES    = 50000;

endpackage

// File: rtl/parking_lane_detector.sv
// One lane: synchronizer, debounce, gate-ack edge detect, request FSM,
// stuck-presence timer and saturating balk counter.
module parking_lane_detector
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int BALK_W          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              loop_raw,
  input  logic              gate_ack,
  output logic              req,
  output logic              fault,
  output logic [BALK_W-1:0] balk_cnt
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0]      DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

  logic               sync1_q, sync2_q;
  logic               clean_q, clean_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic               ack_q;
  lane_state_t        state_q, state_d;
  logic [STUCK_W-1:0] stuck_q, stuck_d;
  logic [BALK_W-1:0]  balk_q, balk_d;
  logic               ack_rise;
  logic               stuck_hit;

  assign ack_rise  = gate_ack & ~ack_q;
  assign stuck_hit = (stuck_q == STUCK_LAST);

  // Any sample agreeing with the clean level restarts the run count.
  always_comb begin
    clean_d = clean_q;
    dcnt_d  = '0;
    if (sync2_q != clean_q) begin
      if (dcnt_q == DCNT_LAST) begin
        clean_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    balk_d  = balk_q;
    case (state_q)
      IDLE: begin
        if (clean_q) state_d = WAIT_GATE;
      end
      WAIT_GATE: begin
        if (ack_rise) begin
          state_d = SERVED;
        end else if (!clean_q) begin
          state_d = IDLE;
          if (balk_q != '1) balk_d = balk_q + 1'b1;
        end else if (stuck_hit) begin
          state_d = FAULT;
        end
      end
      SERVED: begin
        if (!clean_q)       state_d = IDLE;
        else if (stuck_hit) state_d = FAULT;
      end
      FAULT: begin
        if (!clean_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Presence timer spans both WAIT_GATE and SERVED and saturates rather than wrapping.
  always_comb begin
    stuck_d = '0;
    if (state_q == WAIT_GATE || state_q == SERVED) begin
      stuck_d = (stuck_q == '1) ? stuck_q : stuck_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      dcnt_q  <= '0;
      ack_q   <= 1'b0;
      state_q <= IDLE;
      stuck_q <= '0;
      balk_q  <= '0;
    end else begin
      sync1_q <= loop_raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      dcnt_q  <= dcnt_d;
      ack_q   <= gate_ack;
      state_q <= state_d;
      stuck_q <= stuck_d;
      balk_q  <= balk_d;
    end
  end

  assign req      = (state_q == WAIT_GATE);
  assign fault    = (state_q == FAULT);
  assign balk_cnt = balk_q;

endmodule

// File: rtl/parking_sensor_frontend.sv
// Entry and exit loop conditioning for the parking controller; two
// independent lane detectors, no arbitration between them.
module parking_sensor_frontend
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int BALK_W          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              entry_loop_raw,
  input  logic              exit_loop_raw,
  input  logic              entry_gate_ack,
  input  logic              exit_gate_ack,
  output logic              entry_req,
  output logic              exit_req,
  output logic              entry_fault,
  output logic              exit_fault,
  output logic [BALK_W-1:0] entry_balk_cnt,
  output logic [BALK_W-1:0] exit_balk_cnt
);

  parking_lane_detector #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .BALK_W         (BALK_W)
  ) u_entry (
    .clk     (clk),
    .reset_n (reset_n),
    .loop_raw(entry_loop_raw),
    .gate_ack(entry_gate_ack),
    .req     (entry_req),
    .fault   (entry_fault),
    .balk_cnt(entry_balk_cnt)
  );

  parking_lane_detector #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .BALK_W         (BALK_W)
  ) u_exit (
    .clk     (clk),
    .reset_n (reset_n),
    .loop_raw(exit_loop_raw),
    .gate_ack(exit_gate_ack),
    .req     (exit_req),
    .fault   (exit_fault),
    .balk_cnt(exit_balk_cnt)
  );

endmodule

// File: tb/tb_parking_sensor_frontend.sv
// Scoreboard bench for parking_sensor_frontend (DEBOUNCE_CYCLES=4, STUCK_CYCLES=100).
// Stimulus pushes expected output-change events; a negedge monitor pops and compares them.
module tb_parking_sensor_frontend;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       entry_loop_raw = 1'b0;
  logic       exit_loop_raw = 1'b0;
  logic       entry_gate_ack = 1'b0;
  logic       exit_gate_ack = 1'b0;
  logic       entry_req, exit_req, entry_fault, exit_fault;
  logic [7:0] entry_balk_cnt, exit_balk_cnt;

  parking_sensor_frontend #(
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES   (100),
    .BALK_W         (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .entry_loop_raw(entry_loop_raw),
    .exit_loop_raw (exit_loop_raw),
    .entry_gate_ack(entry_gate_ack),
    .exit_gate_ack (exit_gate_ack),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .entry_fault   (entry_fault),
    .exit_fault    (exit_fault),
    .entry_balk_cnt(entry_balk_cnt),
    .exit_balk_cnt (exit_balk_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index: value seen after posedge N equals N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cycle;
    logic [19:0] vec;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        m_er = 0, m_xr = 0, m_ef = 0, m_xf = 0;
  logic [7:0]  m_eb = 0, m_xb = 0;
  bit          mon_en = 0;
  logic [19:0] prev_vec = '0;
  logic [19:0] dut_vec;

  assign dut_vec = {entry_req, exit_req, entry_fault, exit_fault, entry_balk_cnt, exit_balk_cnt};

  function automatic logic [19:0] modelVec();
    return {m_er, m_xr, m_ef, m_xf, m_eb, m_xb};
  endfunction

  task automatic pushExp(input int c);
    exp_t e;
    e.cycle = c;
    e.vec   = modelVec();
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [19:0] act, input logic [19:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, want);
    end
  endtask

  task automatic applyStimulus(input logic er, input logic xr, input logic ea, input logic xa);
    entry_loop_raw = er;
    exit_loop_raw  = xr;
    entry_gate_ack = ea;
    exit_gate_ack  = xa;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) tick(1);
  endtask

  // Monitor: every change of the output bundle must match the next expected event.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && dut_vec !== prev_vec) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_change at cycle %0d: actual %h previous %h", cyc, dut_vec, prev_vec);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("event_at_%0d", e.cycle), dut_vec, e.vec);
        n_checks++;
        if (cyc != e.cycle) begin
          n_fail++;
          $display("[TB] FAIL event_at_%0d_cycle: actual %0d required %0d", e.cycle, cyc, e.cycle);
        end
      end
      prev_vec = dut_vec;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, f, b, g, t, p;
    $display("[TB] start");
    #2 reset_n = 1'b0;
    tick(3);
    checkOutput("reset_state", dut_vec, 20'h0);
    reset_n  = 1'b1;
    prev_vec = dut_vec;
    mon_en   = 1;
    tick(2);

    // Clean arrival, service, no reassert while present, second car.
    e0 = cyc;
    applyStimulus(1, 0, 0, 0);
    m_er = 1; pushExp(e0 + 7);
    waitUntil(e0 + 12);
    applyStimulus(1, 0, 1, 0);
    m_er = 0; pushExp(e0 + 13);
    waitUntil(e0 + 14); applyStimulus(1, 0, 0, 0);
    waitUntil(e0 + 20); applyStimulus(0, 0, 0, 0);
    waitUntil(e0 + 30); applyStimulus(1, 0, 0, 0);
    m_er = 1; pushExp(e0 + 37);
    waitUntil(e0 + 40); applyStimulus(1, 0, 1, 0);
    m_er = 0; pushExp(e0 + 41);
    waitUntil(e0 + 42); applyStimulus(1, 0, 0, 0);
    waitUntil(e0 + 45); applyStimulus(0, 0, 0, 0);
    waitUntil(e0 + 55);

    // Bounce: high and low runs of 1..3 cycles never reach the clean level.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 0);
      tick((i % 3) + 1);
      applyStimulus(0, 0, 0, 0);
      tick(((i + 1) % 3) + 1);
    end
    f = cyc;
    applyStimulus(1, 0, 0, 0);
    m_er = 1; pushExp(f + 7);
    waitUntil(f + 10); applyStimulus(1, 0, 1, 0);
    m_er = 0; pushExp(f + 11);
    waitUntil(f + 12); applyStimulus(1, 0, 0, 0);
    waitUntil(f + 13); applyStimulus(0, 0, 0, 0);
    waitUntil(f + 22);

    // Exit balk, then drive the counter into saturation (300 balks total).
    b = cyc;
    applyStimulus(0, 1, 0, 0);
    m_xr = 1; pushExp(b + 7);
    waitUntil(b + 10); applyStimulus(0, 0, 0, 0);
    m_xr = 0; m_xb = 8'd1; pushExp(b + 17);
    waitUntil(b + 20);
    for (int k = 1; k < 300; k++) begin
      b = cyc;
      applyStimulus(0, 1, 0, 0);
      m_xr = 1; pushExp(b + 7);
      waitUntil(b + 8); applyStimulus(0, 0, 0, 0);
      m_xr = 0;
      if (m_xb != 8'd255) m_xb = m_xb + 8'd1;
      pushExp(b + 15);
      waitUntil(b + 16);
    end
    checkOutput("balk_saturated", {12'h0, exit_balk_cnt}, 20'd255);

    // Stale gate: ack already high when the request appears.
    g = cyc;
    applyStimulus(0, 0, 1, 0);
    waitUntil(g + 1); applyStimulus(1, 0, 1, 0);
    m_er = 1; pushExp(g + 8);
    waitUntil(g + 15); applyStimulus(1, 0, 0, 0);
    waitUntil(g + 17); applyStimulus(1, 0, 1, 0);
    m_er = 0; pushExp(g + 18);
    waitUntil(g + 19); applyStimulus(0, 0, 0, 0);
    waitUntil(g + 30);

    // Stuck entry loop: fault exactly 100 cycles after WAIT_GATE entry.
    t = cyc;
    applyStimulus(1, 0, 0, 0);
    m_er = 1; pushExp(t + 7);
    m_er = 0; m_ef = 1; pushExp(t + 107);
    waitUntil(t + 110); applyStimulus(0, 0, 0, 0);
    m_ef = 0; pushExp(t + 117);
    waitUntil(t + 120);

    // Simultaneous arrival, then async reset in the middle of WAIT_GATE.
    p = cyc;
    applyStimulus(1, 1, 0, 0);
    m_er = 1; m_xr = 1; pushExp(p + 7);
    waitUntil(p + 10);
    #2;
    m_er = 0; m_xr = 0; m_ef = 0; m_xf = 0; m_eb = 0; m_xb = 0;
    pushExp(p + 10);
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    #1;
    checkOutput("async_reset", dut_vec, 20'h0);
    waitUntil(p + 12);
    reset_n = 1'b1;
    tick(20);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL pending_events: actual %0d outstanding required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
